// File: rtl/bus_reg_target.sv
// bus_reg_target: byte-wide register file terminating the five-channel valid/ready bus
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   addr_read_bus_*           read address in (8-bit), ready out
//   data_read_bus_*           read data out (8-bit), one-cycle latency, 8'h00 if out of range
//   addr_write_bus_*          write address in, held until commit
//   data_write_bus_*          write data in, held until commit
//   resp_write_bus_*          write status out: 8'h00 OK, 8'h01 out of range
module bus_reg_target #(
  parameter int DEPTH = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_read_bus_data,
  input  logic       addr_read_bus_valid,
  output logic       addr_read_bus_ready,
  output logic [7:0] data_read_bus_data,
  output logic       data_read_bus_valid,
  input  logic       data_read_bus_ready,
  input  logic [7:0] addr_write_bus_data,
  input  logic       addr_write_bus_valid,
  output logic       addr_write_bus_ready,
  input  logic [7:0] data_write_bus_data,
  input  logic       data_write_bus_valid,
  output logic       data_write_bus_ready,
  output logic [7:0] resp_write_bus_data,
  output logic       resp_write_bus_valid,
  input  logic       resp_write_bus_ready
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [8:0] LIM = 9'(DEPTH);
  logic [7:0] r_mem [DEPTH];
  logic       r_aw_held, r_w_held, r_rd_valid, r_resp_valid;
  logic [7:0] r_aw_addr, r_w_data, r_rd_data, r_resp_data;
  logic       w_ar_fire, w_ar_in, w_aw_in, w_commit;
  assign addr_read_bus_ready  = !r_rd_valid || data_read_bus_ready;
  assign addr_write_bus_ready = !r_aw_held;
  assign data_write_bus_ready = !r_w_held;
  assign data_read_bus_valid  = r_rd_valid;
  assign data_read_bus_data   = r_rd_data;
  assign resp_write_bus_valid = r_resp_valid;
  assign resp_write_bus_data  = r_resp_data;
  assign w_ar_fire = addr_read_bus_valid && addr_read_bus_ready;
  assign w_ar_in   = {1'b0, addr_read_bus_data} < LIM;
  assign w_aw_in   = {1'b0, r_aw_addr} < LIM;
  // a pending response that is not being consumed stalls the commit
  assign w_commit  = r_aw_held && r_w_held && (!r_resp_valid || resp_write_bus_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VALUE;
      r_aw_held    <= 1'b0;
      r_w_held     <= 1'b0;
      r_aw_addr    <= 8'h00;
      r_w_data     <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= 8'h00;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 8'h00;
    end else begin
      // read samples the pre-commit contents, so a same-edge write returns the old value
      if (w_ar_fire) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_ar_in ? r_mem[addr_read_bus_data[AW-1:0]] : 8'h00;
      end else if (data_read_bus_ready) begin
        r_rd_valid <= 1'b0;
      end
      // commit needs both holds full, so it never coincides with a new accept
      if (w_commit) begin
        r_aw_held <= 1'b0;
      end else if (addr_write_bus_valid && !r_aw_held) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= addr_write_bus_data;
      end
      if (w_commit) begin
        r_w_held <= 1'b0;
      end else if (data_write_bus_valid && !r_w_held) begin
        r_w_held <= 1'b1;
        r_w_data <= data_write_bus_data;
      end
      if (w_commit && w_aw_in) r_mem[r_aw_addr[AW-1:0]] <= r_w_data;
      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_aw_in ? 8'h00 : 8'h01;
      end else if (resp_write_bus_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_reg_target.sv
// tb_bus_reg_target: scoreboard bench for bus_reg_target
module tb_bus_reg_target;
  localparam int DEPTH = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] addr_read_bus_data = 8'h00, data_read_bus_data;
  logic addr_read_bus_valid = 1'b0, addr_read_bus_ready;
  logic data_read_bus_valid, data_read_bus_ready = 1'b1;
  logic [7:0] addr_write_bus_data = 8'h00, data_write_bus_data = 8'h00, resp_write_bus_data;
  logic addr_write_bus_valid = 1'b0, addr_write_bus_ready;
  logic data_write_bus_valid = 1'b0, data_write_bus_ready;
  logic resp_write_bus_valid, resp_write_bus_ready = 1'b1;
  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] mdl [256];
  logic [7:0] rq [$];
  logic [7:0] wq [$];
  int rd_cyc [$];
  bus_reg_target #(.DEPTH(DEPTH), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst),
    .addr_read_bus_data(addr_read_bus_data), .addr_read_bus_valid(addr_read_bus_valid),
    .addr_read_bus_ready(addr_read_bus_ready),
    .data_read_bus_data(data_read_bus_data), .data_read_bus_valid(data_read_bus_valid),
    .data_read_bus_ready(data_read_bus_ready),
    .addr_write_bus_data(addr_write_bus_data), .addr_write_bus_valid(addr_write_bus_valid),
    .addr_write_bus_ready(addr_write_bus_ready),
    .data_write_bus_data(data_write_bus_data), .data_write_bus_valid(data_write_bus_valid),
    .data_write_bus_ready(data_write_bus_ready),
    .resp_write_bus_data(resp_write_bus_data), .resp_write_bus_valid(resp_write_bus_valid),
    .resp_write_bus_ready(resp_write_bus_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && data_read_bus_valid && data_read_bus_ready) begin
      if (rq.size() == 0) check("rd_unexpected", 1, 0);
      else check("rd_data", data_read_bus_data, rq.pop_front());
      rd_cyc.push_back(cyc);
    end
    if (!rst && resp_write_bus_valid && resp_write_bus_ready) begin
      if (wq.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp_data", resp_write_bus_data, wq.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic ar(input logic [7:0] a);
    int t = 0;
    addr_read_bus_data = a;
    addr_read_bus_valid = 1'b1;
    @(negedge clk);
    while (!addr_read_bus_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("ar_timeout", 1, 0);
    rq.push_back(a < DEPTH ? mdl[a] : 8'h00);
    @(posedge clk);
    #1 addr_read_bus_valid = 1'b0;
  endtask
  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
    wq.push_back(a < DEPTH ? 8'h00 : 8'h01);
    if (a < DEPTH) mdl[a] = d;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    int t = 0;
    exp_wr(a, d);
    addr_write_bus_data = a;
    data_write_bus_data = d;
    addr_write_bus_valid = 1'b1;
    data_write_bus_valid = 1'b1;
    @(negedge clk);
    while (!(addr_write_bus_ready && data_write_bus_ready) && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("wr_timeout", 1, 0);
    @(posedge clk);
    #1;
    addr_write_bus_valid = 1'b0;
    data_write_bus_valid = 1'b0;
  endtask
  task automatic wd(input logic [7:0] d);
    int t = 0;
    data_write_bus_data = d;
    data_write_bus_valid = 1'b1;
    @(negedge clk);
    while (!data_write_bus_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("w_timeout", 1, 0);
    @(posedge clk);
    #1 data_write_bus_valid = 1'b0;
  endtask
  task automatic wa(input logic [7:0] a);
    int t = 0;
    addr_write_bus_data = a;
    addr_write_bus_valid = 1'b1;
    @(negedge clk);
    while (!addr_write_bus_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("aw_timeout", 1, 0);
    @(posedge clk);
    #1 addr_write_bus_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || wq.size() != 0) && t < 100) begin @(negedge clk); t++; end
    check("drain", rq.size() + wq.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic rd_all();
    for (int i = 0; i < DEPTH; i++) ar(8'(i));
    drain();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_rd_valid", data_read_bus_valid, 0);
    check("rst_resp_valid", resp_write_bus_valid, 0);
    check("rst_rd_data", data_read_bus_data, 0);
    check("rst_resp_data", resp_write_bus_data, 0);
    check("rst_ar_ready", addr_read_bus_ready, 1);
    check("rst_aw_ready", addr_write_bus_ready, 1);
    check("rst_w_ready", data_write_bus_ready, 1);
    rd_all();
    wr(8'h03, 8'hA5);
    check("wr_lat_n", resp_write_bus_valid, 0);
    @(posedge clk);
    #1 check("wr_lat_n1", resp_write_bus_valid, 1);
    drain();
    ar(8'h03);
    check("rd_lat", data_read_bus_valid, 1);
    drain();
    exp_wr(8'h07, 8'h3C);
    wd(8'h3C);
    repeat (3) begin
      @(posedge clk);
      #1 check("w_held_ready", data_write_bus_ready, 0);
    end
    wa(8'h07);
    check("skew_lat_n", resp_write_bus_valid, 0);
    @(posedge clk);
    #1;
    check("skew_lat_n1", resp_write_bus_valid, 1);
    check("skew_w_ready", data_write_bus_ready, 1);
    drain();
    ar(8'h07);
    drain();
    wr(8'h10, 8'hFF);
    drain();
    ar(8'h10);
    rd_all();
    resp_write_bus_ready = 1'b0;
    wr(8'h01, 8'h11);
    wr(8'h20, 8'h22);
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_aw_ready", addr_write_bus_ready, 0);
      check("bp_w_ready", data_write_bus_ready, 0);
      check("bp_resp_valid", resp_write_bus_valid, 1);
      check("bp_resp_data", resp_write_bus_data, 8'h00);
    end
    resp_write_bus_ready = 1'b1;
    drain();
    ar(8'h01);
    ar(8'h20);
    drain();
    rd_cyc.delete();
    for (int i = 0; i < 4; i++) ar(8'(i + 1));
    drain();
    check("stream_beats", rd_cyc.size(), 4);
    for (int i = 1; i < rd_cyc.size(); i++) check("stream_gap", rd_cyc[i] - rd_cyc[i-1], 1);
    data_read_bus_ready = 1'b0;
    ar(8'h05);
    check("pend_valid", data_read_bus_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_valid", data_read_bus_valid, 0);
    rq.delete();
    for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
    data_read_bus_ready = 1'b1;
    rd_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
